// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator.
// Free-running h/v counters produce sync and active-area timing. One of four
// patterns is rendered from the active-area coordinates: bars, grid, gradient
// or bouncing box. Every output is registered, so the outputs lag the counters
// by exactly one clock and stay aligned with each other. The pattern select and
// the box position change only on the first clock of a frame. That clock is in
// blanking, so a frame is never drawn with two different settings.
module video_pattern_gen #(
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int H_ACTIVE   = 640,
  parameter int H_FRONT    = 16,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int V_ACTIVE   = 480,
  parameter int V_FRONT    = 10,
  parameter int SYNC_POL   = 1,
  parameter int COLOR_W    = 8,
  parameter int CNT_W      = 12,
  parameter int GRID       = 32,
  parameter int GRAD_SHIFT = 2,
  parameter int BOX_SIZE   = 64
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic [1:0]         mode_sel,
  output logic               hsync,
  output logic               vsync,
  output logic               rgb_valid,
  output logic [COLOR_W-1:0] rgb_r,
  output logic [COLOR_W-1:0] rgb_g,
  output logic [COLOR_W-1:0] rgb_b,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int BAR_W   = H_ACTIVE / 8;

  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_START = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_START = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_END   = CNT_W'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [CNT_W-1:0] BOX_X_MAX   = CNT_W'(H_ACTIVE - BOX_SIZE);
  localparam logic [CNT_W-1:0] BOX_Y_MAX   = CNT_W'(V_ACTIVE - BOX_SIZE);
  localparam logic [CNT_W-1:0] BOX_LEN     = CNT_W'(BOX_SIZE);
  localparam logic [CNT_W-1:0] GRID_MASK   = CNT_W'(GRID - 1);
  localparam logic             SYNC_ON     = (SYNC_POL != 0);
  localparam logic [COLOR_W-1:0] FULL      = {COLOR_W{1'b1}};

  logic [CNT_W-1:0]   h_cnt_reg, v_cnt_reg;
  logic [CNT_W-1:0]   box_x_reg, box_y_reg;
  logic               box_x_dec_reg, box_y_dec_reg;   // 1 = moving towards 0
  logic [1:0]         mode_reg;

  logic               frame_first, h_wrap;
  logic               h_in_sync, v_in_sync, in_act;
  logic [CNT_W-1:0]   x_off, y_off, grad_x;
  logic [7:1]         bar_ge;
  logic [2:0]         bar_idx;
  logic               grid_line, in_box;
  logic [COLOR_W-1:0] pat_r, pat_g, pat_b;

  assign frame_first = (h_cnt_reg == '0) && (v_cnt_reg == '0);
  assign h_wrap      = (h_cnt_reg == H_LAST);
  assign h_in_sync   = (h_cnt_reg < H_SYNC_END);
  assign v_in_sync   = (v_cnt_reg < V_SYNC_END);
  assign in_act      = (h_cnt_reg >= H_ACT_START) && (h_cnt_reg < H_ACT_END) &&
                       (v_cnt_reg >= V_ACT_START) && (v_cnt_reg < V_ACT_END);
  // Offsets are only meaningful inside the active area; outside it they are ignored.
  assign x_off       = h_cnt_reg - H_ACT_START;
  assign y_off       = v_cnt_reg - V_ACT_START;
  assign grad_x      = x_off >> GRAD_SHIFT;
  assign grid_line   = ((x_off & GRID_MASK) == '0) || ((y_off & GRID_MASK) == '0);
  assign in_box      = (x_off >= box_x_reg) && (x_off < box_x_reg + BOX_LEN) &&
                       (y_off >= box_y_reg) && (y_off < box_y_reg + BOX_LEN);

  // Bar edges are compared against constants, so no divider is needed for
  // bar widths that are not a power of two.
  genvar gi;
  generate
    for (gi = 1; gi < 8; gi++) begin : g_bar_edge
      localparam logic [CNT_W-1:0] EDGE = CNT_W'(gi * BAR_W);
      assign bar_ge[gi] = (x_off >= EDGE);
    end
  endgenerate

  // Bar index = number of bar edges at or left of the pixel.
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (bar_ge[k]) bar_idx = 3'(k);
    end
  end

  // Pattern colour. The bar order white..black maps each channel to one inverted index bit.
  always_comb begin
    pat_r = '0;
    pat_g = '0;
    pat_b = '0;
    case (mode_reg)
      2'd0: begin
        pat_r = {COLOR_W{~bar_idx[1]}};
        pat_g = {COLOR_W{~bar_idx[2]}};
        pat_b = {COLOR_W{~bar_idx[0]}};
      end
      2'd1: begin
        if (grid_line) begin
          pat_r = FULL;
          pat_g = FULL;
          pat_b = FULL;
        end
      end
      2'd2: begin
        pat_r = grad_x[COLOR_W-1:0];
        pat_g = grad_x[COLOR_W-1:0];
        pat_b = grad_x[COLOR_W-1:0];
      end
      default: begin
        if (in_box) pat_r = FULL;
      end
    endcase
  end

  // Timing counters, plus the once-per-frame mode latch and box step.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      h_cnt_reg     <= '0;
      v_cnt_reg     <= '0;
      mode_reg      <= 2'd0;
      box_x_reg     <= '0;
      box_y_reg     <= '0;
      box_x_dec_reg <= 1'b0;
      box_y_dec_reg <= 1'b0;
    end else begin
      h_cnt_reg <= h_wrap ? '0 : h_cnt_reg + 1'b1;
      if (h_wrap) v_cnt_reg <= (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + 1'b1;
      if (frame_first) begin
        mode_reg <= mode_sel;
        if (!box_x_dec_reg) begin
          if (box_x_reg == BOX_X_MAX) begin
            box_x_dec_reg <= 1'b1;
            box_x_reg     <= box_x_reg - 1'b1;
          end else begin
            box_x_reg     <= box_x_reg + 1'b1;
          end
        end else if (box_x_reg == '0) begin
          box_x_dec_reg <= 1'b0;
          box_x_reg     <= CNT_W'(1);
        end else begin
          box_x_reg     <= box_x_reg - 1'b1;
        end
        if (!box_y_dec_reg) begin
          if (box_y_reg == BOX_Y_MAX) begin
            box_y_dec_reg <= 1'b1;
            box_y_reg     <= box_y_reg - 1'b1;
          end else begin
            box_y_reg     <= box_y_reg + 1'b1;
          end
        end else if (box_y_reg == '0) begin
          box_y_dec_reg <= 1'b0;
          box_y_reg     <= CNT_W'(1);
        end else begin
          box_y_reg     <= box_y_reg - 1'b1;
        end
      end
    end
  end

  // Output stage: one register layer for all outputs keeps them mutually aligned.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      hsync       <= ~SYNC_ON;
      vsync       <= ~SYNC_ON;
      rgb_valid   <= 1'b0;
      rgb_r       <= '0;
      rgb_g       <= '0;
      rgb_b       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
    end else begin
      hsync       <= h_in_sync ? SYNC_ON : ~SYNC_ON;
      vsync       <= v_in_sync ? SYNC_ON : ~SYNC_ON;
      rgb_valid   <= in_act;
      frame_start <= frame_first;
      if (in_act) begin
        pix_x <= x_off;
        pix_y <= y_off;
        rgb_r <= pat_r;
        rgb_g <= pat_g;
        rgb_b <= pat_b;
      end else begin
        pix_x <= '0;
        pix_y <= '0;
        rgb_r <= '0;
        rgb_g <= '0;
        rgb_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen. Five instances share one clock:
// default timing for the sync and reset checks, plus small-timing instances for
// bars/mode change, grid/box area, box bounce and gradient wrap.
module tb_video_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_v  [5];
  logic [1:0]  mode_v [5];
  logic        hs [5], vs [5], rv [5], fs [5];
  logic [7:0]  rr [5], gg [5], bb [5];
  logic [11:0] px [5], py [5];

  int n_tests = 0;
  int n_fail  = 0;

  // Default 640x480 timing
  video_pattern_gen u_a (
    .sys_clk(clk), .sys_rst(rst_v[0]), .mode_sel(mode_v[0]),
    .hsync(hs[0]), .vsync(vs[0]), .rgb_valid(rv[0]),
    .rgb_r(rr[0]), .rgb_g(gg[0]), .rgb_b(bb[0]),
    .pix_x(px[0]), .pix_y(py[0]), .frame_start(fs[0]));

  // 640 wide, 4 lines tall: bars, frame counts, mode change
  video_pattern_gen #(.H_SYNC(4), .H_BACK(4), .H_ACTIVE(640), .H_FRONT(4),
                      .V_SYNC(1), .V_BACK(1), .V_ACTIVE(4), .V_FRONT(1)) u_b (
    .sys_clk(clk), .sys_rst(rst_v[1]), .mode_sel(mode_v[1]),
    .hsync(hs[1]), .vsync(vs[1]), .rgb_valid(rv[1]),
    .rgb_r(rr[1]), .rgb_g(gg[1]), .rgb_b(bb[1]),
    .pix_x(px[1]), .pix_y(py[1]), .frame_start(fs[1]));

  // 128x96: grid and box area
  video_pattern_gen #(.H_SYNC(2), .H_BACK(2), .H_ACTIVE(128), .H_FRONT(2),
                      .V_SYNC(1), .V_BACK(1), .V_ACTIVE(96), .V_FRONT(1),
                      .BOX_SIZE(64)) u_c (
    .sys_clk(clk), .sys_rst(rst_v[2]), .mode_sel(mode_v[2]),
    .hsync(hs[2]), .vsync(vs[2]), .rgb_valid(rv[2]),
    .rgb_r(rr[2]), .rgb_g(gg[2]), .rgb_b(bb[2]),
    .pix_x(px[2]), .pix_y(py[2]), .frame_start(fs[2]));

  // 16x12 with 8-pixel box: bounce over many frames
  video_pattern_gen #(.H_SYNC(1), .H_BACK(1), .H_ACTIVE(16), .H_FRONT(1),
                      .V_SYNC(1), .V_BACK(1), .V_ACTIVE(12), .V_FRONT(1),
                      .BOX_SIZE(8)) u_d (
    .sys_clk(clk), .sys_rst(rst_v[3]), .mode_sel(mode_v[3]),
    .hsync(hs[3]), .vsync(vs[3]), .rgb_valid(rv[3]),
    .rgb_r(rr[3]), .rgb_g(gg[3]), .rgb_b(bb[3]),
    .pix_x(px[3]), .pix_y(py[3]), .frame_start(fs[3]));

  // 1280 wide single line: gradient wrap
  video_pattern_gen #(.H_SYNC(1), .H_BACK(1), .H_ACTIVE(1280), .H_FRONT(1),
                      .V_SYNC(1), .V_BACK(1), .V_ACTIVE(1), .V_FRONT(1)) u_e (
    .sys_clk(clk), .sys_rst(rst_v[4]), .mode_sel(mode_v[4]),
    .hsync(hs[4]), .vsync(vs[4]), .rgb_valid(rv[4]),
    .rgb_r(rr[4]), .rgb_g(gg[4]), .rgb_b(bb[4]),
    .pix_x(px[4]), .pix_y(py[4]), .frame_start(fs[4]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s = %0h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [23:0] rgb_of(input int i);
    return {rr[i], gg[i], bb[i]};
  endfunction

  // Reset instance i with mode m; returns while sampling the first output cycle.
  task automatic start(input int i, input logic [1:0] m);
    @(negedge clk);
    mode_v[i] = m;
    rst_v[i]  = 1'b1;
    @(negedge clk);
    rst_v[i]  = 1'b0;
    tick();
  endtask

  task automatic wait_pix(input int i, input int x, input int y, input string tag);
    int n = 0;
    while (!(rv[i] === 1'b1 && px[i] == x && py[i] == y) && n < 40000) begin
      tick();
      n++;
    end
    check_eq({tag, "_found"}, (n < 40000), 1);
  endtask

  task automatic wait_fs(input int i, input string tag);
    int n = 0;
    while (fs[i] !== 1'b1 && n < 40000) begin
      tick();
      n++;
    end
    check_eq({tag, "_found"}, (n < 40000), 1);
  endtask

  initial begin
    int n, m, k, nv, mx, my, nfs, nred, rminx, rminy, rmaxx;
    logic [23:0] c0, c80, c400, c639, c_late;
    int ex [17] = '{1,2,3,4,5,6,7,8,7,6,5,4,3,2,1,0,1};
    int ey [17] = '{1,2,3,4,3,2,1,0,1,2,3,4,3,2,1,0,1};

    for (int i = 0; i < 5; i++) begin
      rst_v[i]  = 1'b1;
      mode_v[i] = 2'd0;
    end

    // ---------------- default timing: reset, sync widths, line period
    start(0, 2'd0);
    check_eq("a_frame_start_first", fs[0], 1);
    check_eq("a_hsync_first", hs[0], 1);
    check_eq("a_vsync_first", vs[0], 1);
    check_eq("a_valid_blank", rv[0], 0);
    check_eq("a_rgb_blank", rgb_of(0), 0);
    n = 0;
    while (hs[0] === 1'b1 && n < 2000) begin n++; tick(); end
    check_eq("a_hsync_width", n, 96);
    check_eq("a_frame_start_pulse", fs[0], 0);
    m = 0;
    while (hs[0] === 1'b0 && m < 2000) begin m++; tick(); end
    check_eq("a_line_period", n + m, 800);
    k = 0;
    while (vs[0] === 1'b1 && k < 5000) begin k++; tick(); end
    check_eq("a_vsync_width", n + m + k, 1600);
    repeat (40) tick();
    check_eq("a_hsync_before_reset", hs[0], 1);
    rst_v[0] = 1'b1;
    #1;
    check_eq("a_rst_hsync", hs[0], 0);
    check_eq("a_rst_vsync", vs[0], 0);
    check_eq("a_rst_valid", rv[0], 0);
    check_eq("a_rst_frame_start", fs[0], 0);
    check_eq("a_rst_pix", {px[0], py[0]}, 0);
    check_eq("a_rst_rgb", rgb_of(0), 0);

    // ---------------- bars, frame counts, mid-frame mode change
    start(1, 2'd0);
    nv = 0; mx = 0; my = 0; nfs = 0;
    c0 = '0; c80 = '0; c400 = '0; c639 = '0; c_late = '0;
    for (int c = 0; c < 4564; c++) begin
      if (fs[1] === 1'b1) nfs++;
      if (rv[1] === 1'b1) begin
        nv++;
        if (px[1] > mx) mx = px[1];
        if (py[1] > my) my = py[1];
        if (py[1] == 0 && px[1] == 0)   c0   = rgb_of(1);
        if (py[1] == 0 && px[1] == 80)  c80  = rgb_of(1);
        if (py[1] == 0 && px[1] == 400) c400 = rgb_of(1);
        if (py[1] == 0 && px[1] == 639) c639 = rgb_of(1);
        if (py[1] == 2 && px[1] == 0)   mode_v[1] = 2'd2;
        if (py[1] == 3 && px[1] == 80)  c_late = rgb_of(1);
      end
      tick();
    end
    check_eq("b_bar_x0", c0, 24'hFFFFFF);
    check_eq("b_bar_x80", c80, 24'hFFFF00);
    check_eq("b_bar_x400", c400, 24'hFF0000);
    check_eq("b_bar_x639", c639, 24'h000000);
    check_eq("b_bar_after_switch", c_late, 24'hFFFF00);
    check_eq("b_valid_count", nv, 2560);
    check_eq("b_pix_x_max", mx, 639);
    check_eq("b_pix_y_max", my, 3);
    check_eq("b_frame_start_count", nfs, 1);
    check_eq("b_frame_period", fs[1], 1);
    wait_pix(1, 12, 0, "b_grad_12");
    check_eq("b_grad_x12", rgb_of(1), 24'h030303);
    wait_pix(1, 639, 0, "b_grad_639");
    check_eq("b_grad_x639", rgb_of(1), 24'h9F9F9F);

    // ---------------- grid, then box area in the next frame
    start(2, 2'd1);
    wait_pix(2, 0, 5, "c_g0_5");
    check_eq("c_grid_0_5", rgb_of(2), 24'hFFFFFF);
    wait_pix(2, 31, 5, "c_g31_5");
    check_eq("c_grid_31_5", rgb_of(2), 24'h000000);
    wait_pix(2, 32, 5, "c_g32_5");
    check_eq("c_grid_32_5", rgb_of(2), 24'hFFFFFF);
    wait_pix(2, 5, 63, "c_g5_63");
    check_eq("c_grid_5_63", rgb_of(2), 24'h000000);
    wait_pix(2, 5, 64, "c_g5_64");
    check_eq("c_grid_5_64", rgb_of(2), 24'hFFFFFF);
    mode_v[2] = 2'd3;
    wait_fs(2, "c_next_frame");
    nred = 0; rminx = 9999; rminy = 9999; rmaxx = 0;
    for (int c = 0; c < 13266; c++) begin
      if (rv[2] === 1'b1 && rgb_of(2) == 24'hFF0000) begin
        nred++;
        if (px[2] < rminx) rminx = px[2];
        if (py[2] < rminy) rminy = py[2];
        if (px[2] > rmaxx) rmaxx = px[2];
      end
      tick();
    end
    check_eq("c_red_count", nred, 4096);
    check_eq("c_box_x_frame2", rminx, 2);
    check_eq("c_box_y_frame2", rminy, 2);
    check_eq("c_box_right_edge", rmaxx, 65);

    // ---------------- box bounce, one frame of 285 clocks each
    start(3, 2'd3);
    for (int f = 0; f < 17; f++) begin
      check_eq($sformatf("d_fs_f%0d", f + 1), fs[3], 1);
      nred = 0; rminx = 9999; rminy = 9999;
      for (int c = 0; c < 285; c++) begin
        if (rv[3] === 1'b1 && rgb_of(3) == 24'hFF0000) begin
          nred++;
          if (px[3] < rminx) rminx = px[3];
          if (py[3] < rminy) rminy = py[3];
        end
        tick();
      end
      check_eq($sformatf("d_box_x_f%0d", f + 1), rminx, ex[f]);
      check_eq($sformatf("d_box_y_f%0d", f + 1), rminy, ey[f]);
      check_eq($sformatf("d_red_f%0d", f + 1), nred, 64);
    end

    // ---------------- gradient wrap at 1280 wide
    start(4, 2'd2);
    wait_pix(4, 12, 0, "e_g12");
    check_eq("e_grad_12", rgb_of(4), 24'h030303);
    wait_pix(4, 1023, 0, "e_g1023");
    check_eq("e_grad_1023", rgb_of(4), 24'hFFFFFF);
    wait_pix(4, 1024, 0, "e_g1024");
    check_eq("e_grad_1024_wrap", rgb_of(4), 24'h000000);
    wait_pix(4, 1028, 0, "e_g1028");
    check_eq("e_grad_1028", rgb_of(4), 24'h010101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
